uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL expose parameter BYTESIZES, default 8, data bits per frame.
REQ-002 The block SHALL expose parameter OVERSAMPLING, default 16, sample ticks per bit; even, >= 4.
REQ-003 The block SHALL expose parameter BAUDRATE, default 115200, line bit rate.
REQ-004 The block SHALL expose parameter CLOCK_INPUT, default 50_000_000, clock frequency in Hz.
REQ-005 The block SHALL have port clock, input, 1, single clock; all flops rise on posedge.
REQ-006 The block SHALL have port nreset, input, 1, reset, asynchronous, active-low.
REQ-007 The block SHALL have port sdata_rx_in, input, 1, asynchronous serial line, idle high.
REQ-008 The block SHALL have port data_rx_out, output, BYTESIZES, last received byte.
REQ-009 The block SHALL have port valid_rx_out, output, 1, data_rx_out holds an unconsumed byte.
REQ-010 The block SHALL have port ready_rx_in, input, 1, consumer accepts the byte.
REQ-011 The block SHALL have port frame_err_out, output, 1, one-clock pulse on a bad stop bit.
REQ-012 The block SHALL have port overrun_err_out, output, 1, one-clock pulse on a lost byte.

Function
REQ-013 The block SHALL synchronize sdata_rx_in through two flops; all decoding uses the synchronized value.
REQ-014 The block SHALL generate a one-clock sample tick every DIV clocks, DIV = CLOCK_INPUT/(BAUDRATE*OVERSAMPLING), truncated, min 1; the divider is free-running from reset.
REQ-015 The FSM SHALL have states IDLE, START, DATA, STOP; all transitions occur on tick cycles only.
REQ-016 IDLE -> START on the first tick seeing synchronized line = 0; the tick counter clears to 0.
REQ-017 Each bit value SHALL be the majority of the samples taken at tick counts OVERSAMPLING/2-1, OVERSAMPLING/2, OVERSAMPLING/2+1 within that bit.
REQ-018 START: a voted 1 is a glitch -> IDLE, no output; a voted 0 -> DATA at tick count OVERSAMPLING-1, bit index 0.
REQ-019 DATA: bits are shifted in LSB first; after bit BYTESIZES-1 completes its OVERSAMPLING ticks -> STOP.
REQ-020 STOP: at tick count OVERSAMPLING/2+1, a voted 1 completes the frame; a voted 0 pulses frame_err_out, discards the byte, and leaves valid_rx_out and data_rx_out unchanged; both cases -> IDLE in that cycle.
REQ-021 On completion, data_rx_out and valid_rx_out=1 SHALL update on the clock edge after the deciding tick (latency 1 clock).
REQ-022 valid_rx_out SHALL stay high with data_rx_out stable until a cycle with valid_rx_out && ready_rx_in; it clears on the next edge.
REQ-023 If a byte completes while valid_rx_out=1 and ready_rx_in=0, the block SHALL overwrite data_rx_out, keep valid_rx_out=1, and pulse overrun_err_out.
REQ-024 If a byte completes in the same cycle as an accept (valid && ready), the new byte SHALL load, valid_rx_out SHALL remain 1, and no overrun SHALL be reported.
REQ-025 A line held low (break) SHALL yield frame_err_out once, then wait in IDLE until the line returns high before arming a new start.

Reset
REQ-026 On nreset low, the block SHALL immediately set FSM=IDLE, counters=0, synchronizer flops=1, data_rx_out=0, valid_rx_out=0, frame_err_out=0, overrun_err_out=0.
REQ-027 A reset asserted mid-frame SHALL abort the frame with no output; reception restarts only on a fresh falling edge after release.

Verification (CLOCK_INPUT=3_200_000, BAUDRATE=100_000, OVERSAMPLING=16: DIV=2, bit=32 clocks)
REQ-028 Frame 0xA5 with a good stop bit and ready_rx_in=1 -> data_rx_out=0xA5 and valid_rx_out high for exactly 1 clock, no error pulses.
REQ-029 Low pulse of 8 clocks on an idle line -> FSM returns to IDLE, valid_rx_out stays 0, no error pulses.
REQ-030 Frame 0x3C with stop bit 0 -> frame_err_out pulses once, valid_rx_out stays 0, data_rx_out unchanged.
REQ-031 Frames 0x11 then 0x22 back-to-back with ready_rx_in=0 -> overrun_err_out pulses once, data_rx_out=0x22, valid_rx_out=1.
REQ-032 nreset asserted during bit 4 of 0xFF, released, then frame 0x5A -> no output for 0xFF, data_rx_out=0x5A received.
REQ-033 A single-clock glitch at the center of a data bit of 0x00 -> majority vote yields 0x00.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, oversampled start/data/stop decoding with a
// 3-sample majority vote per bit, and a single-entry valid/ready output register.
module uart_rx #(
  parameter int unsigned BYTESIZES    = 8,
  parameter int unsigned OVERSAMPLING = 16,
  parameter int unsigned BAUDRATE     = 115200,
  parameter int unsigned CLOCK_INPUT  = 50_000_000
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 sdata_rx_in,
  output logic [BYTESIZES-1:0] data_rx_out,
  output logic                 valid_rx_out,
  input  logic                 ready_rx_in,
  output logic                 frame_err_out,
  output logic                 overrun_err_out
);

  localparam int unsigned DivRaw = CLOCK_INPUT / (BAUDRATE * OVERSAMPLING);
  localparam int unsigned Div    = (DivRaw == 0) ? 1 : DivRaw;
  localparam int unsigned DivW   = (Div > 1) ? $clog2(Div) : 1;
  localparam int unsigned CntW   = $clog2(OVERSAMPLING);
  localparam int unsigned IdxW   = (BYTESIZES > 1) ? $clog2(BYTESIZES) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(Div - 1);
  localparam logic [CntW-1:0] SampLo  = CntW'(OVERSAMPLING / 2 - 1);
  localparam logic [CntW-1:0] SampMid = CntW'(OVERSAMPLING / 2);
  localparam logic [CntW-1:0] SampHi  = CntW'(OVERSAMPLING / 2 + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLING - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(BYTESIZES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  logic                 sync1_q, sync2_q;
  logic [DivW-1:0]      div_q;
  logic                 tick;
  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic [IdxW-1:0]      idx_q;
  logic [1:0]           votes_q;
  logic [BYTESIZES-1:0] shift_q;
  logic                 armed_q;
  logic [1:0]           ones;
  logic                 voted;
  logic                 sample_early;
  logic                 at_decide;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      div_q   <= '0;
    end else begin
      sync1_q <= sdata_rx_in;
      sync2_q <= sync1_q;
      div_q   <= tick ? '0 : div_q + 1'b1;
    end
  end

  assign tick         = (div_q == DivLast);
  // Third vote is the live sample at the deciding tick.
  assign ones         = votes_q + {1'b0, sync2_q};
  assign voted        = ones[1];
  assign sample_early = (cnt_q == SampLo) || (cnt_q == SampMid);
  assign at_decide    = (cnt_q == SampHi);

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      idx_q           <= '0;
      votes_q         <= '0;
      shift_q         <= '0;
      armed_q         <= 1'b0;
      data_rx_out     <= '0;
      valid_rx_out    <= 1'b0;
      frame_err_out   <= 1'b0;
      overrun_err_out <= 1'b0;
    end else begin
      frame_err_out   <= 1'b0;
      overrun_err_out <= 1'b0;
      if (valid_rx_out && ready_rx_in) valid_rx_out <= 1'b0;
      if (tick) begin
        unique case (state_q)
          StIdle: begin
            // After a break, a high line must be seen before a new start is armed.
            if (sync2_q) begin
              armed_q <= 1'b1;
            end else if (armed_q) begin
              state_q <= StStart;
              cnt_q   <= '0;
              votes_q <= '0;
            end
          end
          StStart: begin
            cnt_q <= cnt_q + 1'b1;
            if (sample_early) votes_q <= ones;
            if (at_decide) votes_q <= '0;
            if (at_decide && voted) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else if (cnt_q == CntLast) begin
              state_q <= StData;
              cnt_q   <= '0;
              idx_q   <= '0;
            end
          end
          StData: begin
            cnt_q <= cnt_q + 1'b1;
            if (sample_early) votes_q <= ones;
            if (at_decide) begin
              votes_q <= '0;
              shift_q <= BYTESIZES'({voted, shift_q} >> 1);
            end
            if (cnt_q == CntLast) begin
              cnt_q <= '0;
              if (idx_q == IdxLast) state_q <= StStop;
              else                  idx_q   <= idx_q + 1'b1;
            end
          end
          StStop: begin
            cnt_q <= cnt_q + 1'b1;
            if (sample_early) votes_q <= ones;
            if (at_decide) begin
              votes_q <= '0;
              cnt_q   <= '0;
              state_q <= StIdle;
              if (voted) begin
                data_rx_out     <= shift_q;
                valid_rx_out    <= 1'b1;
                overrun_err_out <= valid_rx_out && !ready_rx_in;
              end else begin
                frame_err_out <= 1'b1;
                armed_q       <= 1'b0;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are driven bit by bit, their expected outcome is queued
// at issue time, and a negedge monitor pops and compares whenever the receiver reports.
module tb_uart_rx;

  localparam int unsigned ClkIn   = 3_200_000;
  localparam int unsigned Baud    = 100_000;
  localparam int unsigned Os      = 16;
  localparam int          BitClks = 32;

  logic       clock = 1'b0;
  logic       nreset = 1'b0;
  logic       sdata_rx_in = 1'b1;
  logic       ready_rx_in = 1'b0;
  logic [7:0] data_rx_out;
  logic       valid_rx_out;
  logic       frame_err_out;
  logic       overrun_err_out;

  always #5 clock = ~clock;

  uart_rx #(
    .BYTESIZES   (8),
    .OVERSAMPLING(Os),
    .BAUDRATE    (Baud),
    .CLOCK_INPUT (ClkIn)
  ) dut (
    .clock          (clock),
    .nreset         (nreset),
    .sdata_rx_in    (sdata_rx_in),
    .data_rx_out    (data_rx_out),
    .valid_rx_out   (valid_rx_out),
    .ready_rx_in    (ready_rx_in),
    .frame_err_out  (frame_err_out),
    .overrun_err_out(overrun_err_out)
  );

  typedef struct packed {
    logic       ferr;
    logic       ovr;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   valid_cycles = 0;
  logic model_pending = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;
  logic mon_load;
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Reference: a good stop bit yields the byte, flagged as overrun if the previous byte is still
  // unconsumed; a bad stop bit yields only a framing error.
  task automatic expect_frame(input logic [7:0] b, input logic stop);
    exp_t e;
    if (!stop) begin
      e = '{ferr: 1'b1, ovr: 1'b0, data: 8'h00};
    end else begin
      e = '{ferr: 1'b0, ovr: model_pending, data: b};
      model_pending = !ready_rx_in;
    end
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit);
    expect_frame(b, stop);
    sdata_rx_in = 1'b0;
    step(BitClks);
    for (int i = 0; i < 8; i++) begin
      sdata_rx_in = b[i];
      if (glitch_bit == i) begin
        step(BitClks / 2);
        sdata_rx_in = ~b[i];
        step(1);
        sdata_rx_in = b[i];
        step(BitClks / 2 - 1);
      end else begin
        step(BitClks);
      end
    end
    sdata_rx_in = stop;
    step(BitClks);
    sdata_rx_in = 1'b1;
  endtask

  // A byte load shows as valid rising, valid held across an accept, or an overrun pulse.
  always @(negedge clock) begin
    if (!nreset) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (valid_rx_out) valid_cycles++;
      mon_load = valid_rx_out && (!prev_valid || prev_ready || overrun_err_out);
      if (frame_err_out || mon_load) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got ferr=%0b data=%0h with nothing expected",
                   frame_err_out, data_rx_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("frame_err", 32'(frame_err_out), 32'(mon_e.ferr));
          if (!mon_e.ferr) begin
            check("rx_data", 32'(data_rx_out), 32'(mon_e.data));
            check("overrun", 32'(overrun_err_out), 32'(mon_e.ovr));
          end
        end
      end
      prev_valid = valid_rx_out;
      prev_ready = ready_rx_in;
    end
  end

  initial begin
    logic [7:0] b;
    logic       stop;
    int         g;
    int         waited;

    step(3);
    check("reset_data", 32'(data_rx_out), 32'h0);
    check("reset_valid", 32'(valid_rx_out), 32'h0);
    check("reset_ferr", 32'(frame_err_out), 32'h0);
    check("reset_ovr", 32'(overrun_err_out), 32'h0);
    nreset = 1'b1;
    step(10);
    ready_rx_in = 1'b1;

    // Good frame with a ready consumer: valid for exactly one clock.
    valid_cycles = 0;
    send_frame(8'hA5, 1'b1, -1);
    step(40);
    check("a5_valid_cycles", 32'(valid_cycles), 32'd1);
    check("a5_data", 32'(data_rx_out), 32'hA5);
    check("a5_valid_after", 32'(valid_rx_out), 32'h0);

    // Short low pulse is rejected as a false start.
    sdata_rx_in = 1'b0;
    step(8);
    sdata_rx_in = 1'b1;
    step(80);
    check("pulse_valid", 32'(valid_rx_out), 32'h0);
    check("pulse_data", 32'(data_rx_out), 32'hA5);

    // Bad stop bit: framing error, output register untouched.
    send_frame(8'h3C, 1'b0, -1);
    step(40);
    check("ferr_valid", 32'(valid_rx_out), 32'h0);
    check("ferr_data", 32'(data_rx_out), 32'hA5);

    // Break: one framing error, then a normal frame once the line idles.
    exp_q.push_back('{ferr: 1'b1, ovr: 1'b0, data: 8'h00});
    sdata_rx_in = 1'b0;
    step(15 * BitClks);
    sdata_rx_in = 1'b1;
    step(40);
    send_frame(8'h96, 1'b1, -1);
    step(40);
    check("after_break_data", 32'(data_rx_out), 32'h96);

    // Back-to-back frames with no consumer: second overwrites and flags overrun.
    ready_rx_in = 1'b0;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    step(40);
    check("ovr_data", 32'(data_rx_out), 32'h22);
    check("ovr_valid", 32'(valid_rx_out), 32'h1);
    ready_rx_in = 1'b1;
    model_pending = 1'b0;
    step(2);
    check("ovr_drained", 32'(valid_rx_out), 32'h0);

    // Reset during bit 4 of 0xFF aborts it; the following frame is received normally.
    sdata_rx_in = 1'b0;
    step(BitClks);
    sdata_rx_in = 1'b1;
    step(4 * BitClks + BitClks / 2);
    nreset = 1'b0;
    step(3);
    check("midrst_data", 32'(data_rx_out), 32'h0);
    check("midrst_valid", 32'(valid_rx_out), 32'h0);
    nreset = 1'b1;
    step(5 * BitClks);
    check("midrst_no_output", 32'(valid_rx_out), 32'h0);
    send_frame(8'h5A, 1'b1, -1);
    step(40);
    check("midrst_next_data", 32'(data_rx_out), 32'h5A);

    // One-clock glitch mid data bit is outvoted.
    send_frame(8'h00, 1'b1, 3);
    step(40);
    check("vote_data", 32'(data_rx_out), 32'h00);

    for (int i = 0; i < 30; i++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      g    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      send_frame(b, stop, g);
      step(int'($urandom_range(8, 40)));
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 400) begin
      step(1);
      waited++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending events expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

endmodule
